// File: rtl/spi_master_pkg.sv
// +----------------------------------------------------------------------+
// | spi_pkg : shared types and constants for the spi_master block        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

    localparam int SPI_WORD_W   = 8;
    localparam int SPI_HALF_CNT = 16;

    localparam logic SCLK_RST_VAL = 1'b0;
    localparam logic CS_RST_VAL   = 1'b1;
    localparam logic MOSI_RST_VAL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
// +----------------------------------------------------------------------+
// | spi_master_if : core-side strobe/byte bus plus the four SPI pins     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface spi_master_if;
    import spi_pkg::*;

    logic                  start;
    logic [SPI_WORD_W-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [SPI_WORD_W-1:0] rx_data;
    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, cs, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, cs, mosi
    );

endinterface

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// +----------------------------------------------------------------------+
// | spi_tick_gen : CLK_DIV down-counter, one-cycle tick on each wrap     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at RELOAD while disabled so the first tick lands exactly CLK_DIV cycles after enable.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;
    end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// +----------------------------------------------------------------------+
// | spi_master : 8-bit MSB-first SPI master, sclk idles low              |
// | Option macro: SPI_MASTER_BURST_EN (start in last HOLD cycle chains)  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);

    spi_state_e            state_q, state_d;
    logic [3:0]            h_q, h_d;
    logic [SPI_WORD_W-1:0] tx_sh_q, tx_sh_d;
    logic [SPI_WORD_W-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_WORD_W-1:0] rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_sh_d = bus.tx_data;
                    rx_sh_d = '0;
                    cs_d    = 1'b0;
                    mosi_d  = bus.tx_data[SPI_WORD_W-1];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    h_d     = 4'd0;
                    sclk_d  = 1'b1;
                    mosi_d  = tx_sh_q[SPI_WORD_W-1];
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    if (!h_q[0]) begin
                        // End of a high phase: slave samples MOSI, we capture MISO.
                        sclk_d  = 1'b0;
                        rx_sh_d = {rx_sh_q[SPI_WORD_W-2:0], bus.miso};
                        tx_sh_d = {tx_sh_q[SPI_WORD_W-2:0], 1'b0};
                        h_d     = h_q + 4'd1;
                    end else if (h_q == 4'(SPI_HALF_CNT - 1)) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        mosi_d = tx_sh_q[SPI_WORD_W-1];
                        h_d    = h_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
`ifdef SPI_MASTER_BURST_EN
                    if (bus.start) begin
                        tx_sh_d = bus.tx_data;
                        rx_sh_d = '0;
                        cs_d    = 1'b0;
                        busy_d  = 1'b1;
                        mosi_d  = bus.tx_data[SPI_WORD_W-1];
                        state_d = SETUP;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            h_q       <= 4'd0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= SCLK_RST_VAL;
            cs_q      <= CS_RST_VAL;
            mosi_q    <= MOSI_RST_VAL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.cs      = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// +----------------------------------------------------------------------+
// | tb_spi_master : self-checking bench for spi_master (CLK_DIV 4 and 2) |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_spi_master;

    localparam int DIV4  = 4;
    localparam int DIV2  = 2;
    localparam int DONE4 = 18 * DIV4 + 1;
    localparam int DONE2 = 18 * DIV2 + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if bus4();
    spi_master_if bus2();

    spi_master #(.CLK_DIV(DIV4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    spi_master #(.CLK_DIV(DIV2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;

    // MISO source for the CLK_DIV=4 master: 0 loopback, 1 constant one, 2 slave model.
    int          miso_mode  = 0;
    logic [7:0]  slave_byte = 8'h00;
    logic        slave_bit  = 1'b0;
    logic [2:0]  slv_idx    = 3'd0;

    assign bus4.miso = (miso_mode == 0) ? bus4.mosi :
                       (miso_mode == 1) ? 1'b1 : slave_bit;
    assign bus2.miso = 1'b1;

    // Slave launches the next MSB-first bit on every sclk rise; cs high realigns it.
    always @(posedge bus4.sclk or posedge bus4.cs) begin
        if (bus4.cs) begin
            slv_idx <= 3'd0;
        end else begin
            slave_bit <= slave_byte[3'd7 - slv_idx];
            slv_idx   <= slv_idx + 3'd1;
        end
    end

    int   rise_total = 0;
    logic mosi_rise_hist [0:1023];
    always @(posedge bus4.sclk) begin
        #1;
        mosi_rise_hist[rise_total % 1024] = bus4.mosi;
        rise_total = rise_total + 1;
    end

    function automatic logic [7:0] mosi_word(input int base);
        logic [7:0] w;
        for (int k = 0; k < 8; k++) w[7-k] = mosi_rise_hist[(base + k) % 1024];
        return w;
    endfunction

    int last_r0;

    // One CLK_DIV=4 transfer, measured cycle by cycle (cycle 1 is the one after acceptance).
    task automatic xfer4(input logic [7:0] tx, input int extra_start_cyc,
                         output int done_cyc, output int n_done, output int rise_cyc,
                         output int n_rise, output logic cs_at1, output int busy_bad,
                         output logic busy_at_done, output logic [7:0] rx_at_done);
        done_cyc = -1; n_done = 0; rise_cyc = -1; busy_bad = 0;
        cs_at1 = 1'bx; busy_at_done = 1'bx; rx_at_done = 8'hxx;
        @(negedge clk);
        bus4.tx_data = tx;
        bus4.start   = 1'b1;
        last_r0      = rise_total;
        @(posedge clk);
        #1;
        bus4.start   = 1'b0;
        bus4.tx_data = 8'($urandom);
        for (int n = 1; n <= DONE4 + 12; n++) begin
            @(negedge clk);
            if (n == 1) cs_at1 = bus4.cs;
            if (bus4.sclk === 1'b1 && rise_cyc < 0) rise_cyc = n;
            if (bus4.done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc     = n;
                    rx_at_done   = bus4.rx_data;
                    busy_at_done = bus4.busy;
                end
            end
            if (n < DONE4 && bus4.busy !== 1'b1) busy_bad++;
            bus4.start = (n == extra_start_cyc);
            if (n == extra_start_cyc) bus4.tx_data = ~tx;
        end
        bus4.start = 1'b0;
        n_rise = rise_total - last_r0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus4.sclk, bus4.cs, bus4.mosi, bus4.busy, bus4.done, bus4.rx_data} !== {5'b01000, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_div4: got sclk,cs,mosi,busy,done,rx=%b%b%b%b%b %h want 01000 00",
                     bus4.sclk, bus4.cs, bus4.mosi, bus4.busy, bus4.done, bus4.rx_data);
        end
        n_checks++;
        if ({bus2.sclk, bus2.cs, bus2.mosi, bus2.busy, bus2.done, bus2.rx_data} !== {5'b01000, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_div2: got sclk,cs,mosi,busy,done,rx=%b%b%b%b%b %h want 01000 00",
                     bus2.sclk, bus2.cs, bus2.mosi, bus2.busy, bus2.done, bus2.rx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_a5();
        int dc, nd, rc, nr, bb; logic c1, bd; logic [7:0] rx;
        miso_mode = 0;
        xfer4(8'hA5, -1, dc, nd, rc, nr, c1, bb, bd, rx);
        n_checks++; if (dc !== DONE4) begin n_errors++; $display("FAIL lb_done_cycle: got %0d want %0d", dc, DONE4); end
        n_checks++; if (rx !== 8'hA5) begin n_errors++; $display("FAIL lb_rx: got %h want a5", rx); end
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL lb_done_count: got %0d want 1", nd); end
        n_checks++; if (rc !== DIV4 + 1) begin n_errors++; $display("FAIL lb_first_rise: got %0d want %0d", rc, DIV4 + 1); end
        n_checks++; if (c1 !== 1'b0) begin n_errors++; $display("FAIL lb_cs_cycle1: got %b want 0", c1); end
        n_checks++; if (bb !== 0) begin n_errors++; $display("FAIL lb_busy_low_cycles: got %0d want 0", bb); end
        n_checks++; if (bd !== 1'b0) begin n_errors++; $display("FAIL lb_busy_at_done: got %b want 0", bd); end
        n_checks++; if (nr !== 8) begin n_errors++; $display("FAIL lb_rise_count: got %0d want 8", nr); end
        n_checks++; if (mosi_word(last_r0) !== 8'hA5) begin n_errors++; $display("FAIL lb_mosi_seq: got %b want 10100101", mosi_word(last_r0)); end
        n_checks++; if (bus4.rx_data !== 8'hA5 || bus4.cs !== 1'b1) begin n_errors++; $display("FAIL lb_hold_after: got rx=%h cs=%b want a5 1", bus4.rx_data, bus4.cs); end
    endtask

    task automatic test_random_slave();
        int dc, nd, rc, nr, bb; logic c1, bd; logic [7:0] rx, tx;
        miso_mode = 2;
        for (int i = 0; i < 6; i++) begin
            tx         = 8'($urandom);
            slave_byte = 8'($urandom);
            xfer4(tx, -1, dc, nd, rc, nr, c1, bb, bd, rx);
            n_checks++; if (rx !== slave_byte) begin n_errors++; $display("FAIL rnd_rx[%0d]: got %h want %h", i, rx, slave_byte); end
            n_checks++; if (mosi_word(last_r0) !== tx) begin n_errors++; $display("FAIL rnd_mosi[%0d]: got %h want %h", i, mosi_word(last_r0), tx); end
            n_checks++; if (dc !== DONE4 || nd !== 1) begin n_errors++; $display("FAIL rnd_done[%0d]: got cycle %0d count %0d want %0d 1", i, dc, nd, DONE4); end
        end
    endtask

    task automatic test_ones_div2();
        int d = -1; logic [7:0] rx = 8'hxx;
        @(negedge clk);
        bus2.tx_data = 8'h00;
        bus2.start   = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        for (int n = 1; n <= DONE2 + 10; n++) begin
            @(negedge clk);
            if (bus2.done === 1'b1 && d < 0) begin d = n; rx = bus2.rx_data; end
        end
        n_checks++; if (d !== DONE2) begin n_errors++; $display("FAIL div2_done_cycle: got %0d want %0d", d, DONE2); end
        n_checks++; if (rx !== 8'hFF) begin n_errors++; $display("FAIL div2_rx: got %h want ff", rx); end
    endtask

    task automatic test_start_ignored();
        int dc, nd, rc, nr, bb; logic c1, bd; logic [7:0] rx, tx;
        miso_mode = 0;
        tx = 8'($urandom);
        xfer4(tx, 20, dc, nd, rc, nr, c1, bb, bd, rx);
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL ign_done_count: got %0d want 1", nd); end
        n_checks++; if (rx !== tx) begin n_errors++; $display("FAIL ign_rx: got %h want %h", rx, tx); end
        n_checks++; if (bus4.rx_data !== tx || nr !== 8) begin n_errors++; $display("FAIL ign_after: got rx=%h rises=%0d want %h 8", bus4.rx_data, nr, tx); end
    endtask

    task automatic test_reset_mid();
        int dc, nd, rc, nr, bb, spurious; logic c1, bd; logic [7:0] rx, tx;
        miso_mode = 0;
        spurious  = 0;
        @(negedge clk);
        bus4.tx_data = 8'h5A;
        bus4.start   = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        for (int n = 1; n < 30; n++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) spurious++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus4.cs, bus4.sclk, bus4.busy, bus4.done} !== 4'b1000) begin
            n_errors++;
            $display("FAIL midrst_pins: got cs,sclk,busy,done=%b%b%b%b want 1000", bus4.cs, bus4.sclk, bus4.busy, bus4.done);
        end
        repeat (3) begin @(negedge clk); if (bus4.done === 1'b1) spurious++; end
        rst_n = 1'b1;
        for (int n = 0; n < DONE4 + 5; n++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) spurious++;
        end
        n_checks++; if (spurious !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d done pulses want 0", spurious); end
        n_checks++; if (bus4.rx_data !== 8'h00) begin n_errors++; $display("FAIL midrst_rx_cleared: got %h want 00", bus4.rx_data); end
        tx = 8'($urandom);
        xfer4(tx, -1, dc, nd, rc, nr, c1, bb, bd, rx);
        n_checks++; if (rx !== tx || dc !== DONE4 || nd !== 1) begin n_errors++; $display("FAIL midrst_recover: got rx=%h cycle=%0d count=%0d want %h %0d 1", rx, dc, nd, tx, DONE4); end
        n_checks++; if (mosi_word(last_r0) !== tx) begin n_errors++; $display("FAIL midrst_mosi: got %h want %h", mosi_word(last_r0), tx); end
    endtask

    task automatic test_back_to_back();
        int dones = 0, cs_high = 0, d1 = -1, d2 = -1, r0, exp_d2, nr;
        logic [7:0] rx1 = 8'hxx, rx2 = 8'hxx;
`ifdef SPI_MASTER_BURST_EN
        exp_d2 = 2 * DONE4 - 1;
`else
        exp_d2 = 2 * DONE4;
`endif
        miso_mode = 0;
        @(negedge clk);
        bus4.tx_data = 8'h3C;
        bus4.start   = 1'b1;
        r0 = rise_total;
        @(posedge clk);
        #1;
        bus4.tx_data = 8'hC3;
        for (int n = 1; n <= 2 * DONE4 + 12; n++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) begin
                dones++;
                if (dones == 1) begin d1 = n; rx1 = bus4.rx_data; end
                if (dones == 2) begin d2 = n; rx2 = bus4.rx_data; end
            end
            if (dones < 2 && bus4.cs === 1'b1) cs_high++;
            if (d1 > 0 && n == d1 + 1) bus4.start = 1'b0;
        end
        bus4.start = 1'b0;
        nr = rise_total - r0;
        n_checks++; if (dones !== 2) begin n_errors++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        n_checks++; if (rx1 !== 8'h3C || rx2 !== 8'hC3) begin n_errors++; $display("FAIL b2b_rx: got %h %h want 3c c3", rx1, rx2); end
        n_checks++; if (nr !== 16) begin n_errors++; $display("FAIL b2b_rises: got %0d want 16", nr); end
        n_checks++; if (d2 !== exp_d2) begin n_errors++; $display("FAIL b2b_second_done: got %0d want %0d", d2, exp_d2); end
`ifdef SPI_MASTER_BURST_EN
        n_checks++; if (cs_high !== 0) begin n_errors++; $display("FAIL b2b_cs_gap: got %0d high cycles want 0", cs_high); end
`else
        n_checks++; if (cs_high < 1) begin n_errors++; $display("FAIL b2b_cs_gap: got %0d high cycles want >=1", cs_high); end
`endif
    endtask

    initial begin
        bus4.start   = 1'b0;
        bus4.tx_data = 8'h00;
        bus2.start   = 1'b0;
        bus2.tx_data = 8'h00;
        test_reset();
        test_loopback_a5();
        test_random_slave();
        test_ones_div2();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
